management_rx_reader: RTL

Drains Ethernet frames that the management RX CDC stage has already moved into the `sys_clk` domain. It pops one 11-bit frame-length header per frame and presents the length to the QSPI register bridge. It then returns the frame's payload one 32-bit word per request, and discards any unread remainder on abort. It sits between the RX packet/header FIFO pair and the QSPI register file.

---
 rtl/management_rx_reader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/management_rx_reader.sv
// Drains length-prefixed RX frames from the header/payload FIFO pair and hands
// them to the QSPI register bridge one 32-bit word per request.
module management_rx_reader (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        rxheader_rd_empty,
    input  logic [10:0] rxheader_rd_data,
    output logic        rxheader_rd_en,
    input  logic [31:0] rxfifo_rd_data,
    output logic        rxfifo_rd_en,
    output logic        rxfifo_rd_pop_single,
    output logic        frame_ready,
    output logic [10:0] frame_len,
    input  logic        word_req,
    output logic        word_valid,
    output logic [31:0] word_data,
    input  logic        frame_abort,
    output logic        frame_done,
    output logic        word_req_err,
    output logic [15:0] rx_frame_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_WAIT = 2'd1,
        READY    = 2'd2,
        DISCARD  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [9:0]  words_left_reg, words_left_next;
    logic [10:0] frame_len_reg;
    logic [31:0] word_hold_reg;
    logic        valid_reg;
    logic        done_reg;
    logic        err_reg;
    logic [15:0] count_reg;

    logic        hdr_pop;
    logic        word_pop;
    logic        deliver;
    logic        finish;
    logic        req_ignored;
    logic [11:0] len_round;

    // Round the byte length up to whole words; 2047 bytes -> 512 words still fits.
    assign len_round = {1'b0, rxheader_rd_data} + 12'd3;

    always_comb begin
        state_next      = state_reg;
        words_left_next = words_left_reg;
        hdr_pop         = 1'b0;
        word_pop        = 1'b0;
        deliver         = 1'b0;
        finish          = 1'b0;
        req_ignored     = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ignored = word_req;
                // The completion pulse cycle is a settling cycle before the next header pop.
                if (!rxheader_rd_empty && !done_reg) begin
                    hdr_pop    = 1'b1;
                    state_next = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                req_ignored     = word_req;
                words_left_next = len_round[11:2];
                state_next      = (rxheader_rd_data == 11'd0) ? IDLE : READY;
            end
            READY: begin
                if (frame_abort) begin
                    // Abort swallows a simultaneous request without flagging it.
                    if (words_left_reg != 10'd0) begin
                        state_next = DISCARD;
                    end
                end else if (word_req) begin
                    if (words_left_reg != 10'd0) begin
                        word_pop        = 1'b1;
                        deliver         = 1'b1;
                        words_left_next = words_left_reg - 10'd1;
                        if (words_left_reg == 10'd1) begin
                            state_next = IDLE;
                            finish     = 1'b1;
                        end
                    end else begin
                        req_ignored = 1'b1;
                    end
                end
            end
            DISCARD: begin
                req_ignored     = word_req;
                word_pop        = 1'b1;
                words_left_next = words_left_reg - 10'd1;
                if (words_left_reg <= 10'd1) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg      <= IDLE;
            words_left_reg <= 10'd0;
            frame_len_reg  <= 11'd0;
            word_hold_reg  <= 32'd0;
            valid_reg      <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            count_reg      <= 16'd0;
        end else begin
            state_reg      <= state_next;
            words_left_reg <= words_left_next;
            valid_reg      <= deliver;
            done_reg       <= finish;
            err_reg        <= req_ignored;
            if (state_reg == HDR_WAIT) begin
                frame_len_reg <= rxheader_rd_data;
            end
            if (finish) begin
                count_reg <= count_reg + 16'd1;
            end
            if (valid_reg) begin
                word_hold_reg <= rxfifo_rd_data;
            end
        end
    end

    // The FIFO presents the popped word one cycle after the pop, so the strobe
    // cycle passes it straight through and the hold register keeps it afterwards.
    assign word_data            = valid_reg ? rxfifo_rd_data : word_hold_reg;
    assign rxheader_rd_en       = hdr_pop && !sys_rst;
    assign rxfifo_rd_en         = word_pop;
    assign rxfifo_rd_pop_single = word_pop;
    assign frame_ready          = (state_reg == READY);
    assign frame_len            = frame_len_reg;
    assign word_valid           = valid_reg;
    assign frame_done           = done_reg;
    assign word_req_err         = err_reg;
    assign rx_frame_count       = count_reg;

endmodule
